// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver (and the future transmitter).
// Contents:
//   state_t    - frame FSM state encoding (ST_IDLE, ST_DATA, ST_PARITY, ST_STOP)
//   START_BIT  - line level that opens a frame
//   STOP_BIT   - line level that closes a good frame
//   LINE_IDLE  - line level between frames
//   par_step   - one step of the running even-parity accumulator
package serial_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;
    localparam logic LINE_IDLE = 1'b0;

    // Fold one more bit into the running XOR of the data bits.
    function automatic logic par_step(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

endpackage

// File: rtl/rx_hold_buf.sv
// One-entry valid/ready holding register for received words.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load_en      - a good frame has just completed; load_data is its word
//   load_data    - received word
//   data_ready   - consumer accepts data_out when data_valid is high
//   data_out     - held word
//   data_valid   - register full
//   overrun      - one-cycle pulse: a good word arrived while full and not drained
module rx_hold_buf
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun
);

    logic accept_s;
    logic free_s;

    // A word leaving this edge frees the slot for a word arriving on the same edge.
    always_comb begin
        accept_s = data_valid & data_ready;
        free_s   = ~data_valid | accept_s;
    end

    // Holding register: load beats drain; a blocked load raises overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= load_en & ~free_s;
            if (load_en && free_s) begin
                data_out   <= load_data;
                data_valid <= 1'b1;
            end else if (accept_s) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit (1), WIDTH data bits LSB first, optional even
// parity bit, stop bit (0). Good words go to a one-entry valid/ready buffer.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   serial_in    - serial line, one bit per clk, idle low
//   data_out     - received word, valid while data_valid
//   data_valid   - holding register full
//   data_ready   - consumer handshake
//   busy         - receiver not in IDLE
//   parity_err   - one-cycle pulse, parity mismatch, frame dropped
//   frame_err    - one-cycle pulse, stop bit was 1, frame dropped
//   overrun      - one-cycle pulse, good frame dropped because the buffer was full
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic             par_acc_r;
    logic             par_bad_r;
    logic             stop_edge_s;
    logic             stop_bad_s;
    logic             word_good_s;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state; bits seen in PARITY/STOP are frame content, never a new start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (serial_in == START_BIT) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (bit_cnt_r == LAST_BIT) begin
                    state_nxt_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: state_nxt_s = ST_STOP;
            ST_STOP:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Frame verdict at the stop-bit edge: stop error outranks parity error.
    always_comb begin
        stop_edge_s = (state_r == ST_STOP);
        stop_bad_s  = (serial_in != STOP_BIT);
        word_good_s = stop_edge_s & ~stop_bad_s & ~par_bad_r;
    end

    // Deserialiser, bit counter and running parity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_r <= '0;
            shift_r   <= '0;
            par_acc_r <= 1'b0;
            par_bad_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= '0;
                    par_acc_r <= 1'b0;
                    par_bad_r <= 1'b0;
                end
                ST_DATA: begin
                    shift_r   <= {serial_in, shift_r[WIDTH-1:1]};
                    par_acc_r <= par_step(par_acc_r, serial_in);
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                end
                ST_PARITY: begin
                    par_bad_r <= par_step(par_acc_r, serial_in);
                end
                default: begin
                    par_bad_r <= par_bad_r;
                end
            endcase
        end
    end

    // Registered status: busy tracks the next state, error pulses last one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            busy       <= (state_nxt_s != ST_IDLE);
            frame_err  <= stop_edge_s & stop_bad_s;
            parity_err <= stop_edge_s & ~stop_bad_s & par_bad_r;
        end
    end

    rx_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst_n      (reset),
        .load_en    (word_good_s),
        .load_data  (shift_r),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun)
    );

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receiving end of the serial bit stream produced by the team's serial shift-register chain: one bit per clk on serial_in.
- Detects a start bit, deserialises a WIDTH-bit word LSB-first, checks optional even parity and the stop bit.
- Presents the word on a one-entry valid/ready output buffer for downstream parallel logic.
- Reports parity, framing and overrun errors as single-cycle pulses.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..32).
- PARITY_EN, 1, 1 = even-parity bit follows the data bits; 0 = no parity bit.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- serial_in  input  1  serial line, one bit per clk; idle level 0.
- data_out  output  WIDTH  received word, valid while data_valid=1.
- data_valid  output  1  holding register full.
- data_ready  input  1  consumer accepts data_out when data_valid & data_ready at a rising edge.
- busy  output  1  high in any state other than IDLE.
- parity_err  output  1  one-cycle pulse: parity mismatch, frame dropped.
- frame_err  output  1  one-cycle pulse: stop bit was 1, frame dropped.
- overrun  output  1  one-cycle pulse: good frame dropped because the holding register was full.

Behaviour:
- Frame format on the wire, one bit per cycle:
  - start bit = 1.
  - WIDTH data bits, LSB first.
  - parity bit, only if PARITY_EN; equals the XOR of the data bits (even parity).
  - stop bit = 0.
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - data_out=0, data_valid=0, busy=0.
  - all error pulses 0; bit counter and shift register cleared.
  - A frame in progress is abandoned silently; a pending word is lost.
- State machine, evaluated at each rising clk:
  - IDLE: serial_in=1 -> DATA with bit_cnt=0; otherwise stay.
  - DATA: shift serial_in into the MSB of the shift register (right shift) and increment bit_cnt. After the WIDTH-th bit -> PARITY if PARITY_EN, else STOP.
  - PARITY: latch the parity check result -> STOP.
  - STOP: evaluate the frame -> IDLE. The next start bit may arrive on the very next cycle, giving back-to-back frames with zero idle cycles.
- Frame evaluation at the STOP edge, in priority order:
  - stop bit=1 -> frame_err pulse; word dropped.
  - parity mismatch -> parity_err pulse; word dropped.
  - holding register free, or being consumed this same edge (data_valid & data_ready) -> load data_out; data_valid=1.
  - otherwise -> overrun pulse; new word dropped; old word kept.
- Latency: data_valid rises on the same edge that samples the stop bit. The start bit is sampled WIDTH+PARITY_EN+1 edges before that.
- Handshake:
  - data_valid & data_ready at an edge clears data_valid, unless a new word loads on that same edge, in which case data_valid stays 1 with the new data.
  - data_out is stable while data_valid=1 and not consumed.
  - data_ready is ignored when data_valid=0.
- Error pulses are high for exactly one cycle, the cycle following the STOP edge. At most one error pulse per frame.
- Parity is computed with a running XOR accumulated during DATA. No extra arithmetic; bit_cnt is clog2(WIDTH+1) bits wide.
- A 1 on serial_in while in STOP or PARITY is treated as frame content, never as a new start bit.

Decomposition:
- Shared package serial_frame_pkg:
  - state encoding constants ST_IDLE, ST_DATA, ST_PARITY, ST_STOP.
  - START_BIT=1, STOP_BIT=0, LINE_IDLE=0.
  - These are shared with the future serial_frame_tx.
- One natural sub-module: rx_hold_buf, the one-entry valid/ready holding register with overrun detection. The FSM and shifter stay in the top module.

Test Plan (WIDTH=8, PARITY_EN=1 unless noted):
- Reset: hold reset=0 with serial_in=1 for 3 cycles -> data_valid=0, busy=0, no error pulses. Release; the first 1 seen after release starts a frame.
- Good frame, data_ready=1: send 0xA5 (bits 1,1,0,1,0,0,1,0,1,0,0) -> data_out=0xA5 and data_valid=1 after the 11th edge, cleared next edge; no error pulses.
- Parity error: send 0x01 with parity bit 0 -> parity_err=1 for one cycle; data_valid stays 0.
- Framing error: send 0x3C with stop bit 1 -> frame_err=1 for one cycle; word dropped; FSM in IDLE.
- Overrun, back-to-back: data_ready=0; send 0x11 then 0x22 with no idle gap -> data_out=0x11 held; overrun pulse at the end of the second frame. Then data_ready=1 -> 0x11 consumed. Repeat with PARITY_EN=0 and frames 10 cycles long.
- Reset mid-frame: assert reset after 4 data bits of 0xFF -> outputs return to reset values immediately. The next clean frame 0x5A is received correctly.
